// File: rtl/mac_vlg_pkg.sv
// Shared types and defaults for the MAC transmit arbiter.
// Provides the arbiter state enum, the latched header struct and index-width helper.
package mac_vlg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      PASS,
      GUARD
   } arb_state_e;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [15:0] ethertype;
      logic [15:0] length;
   } mac_hdr_t;

   localparam int GUARD_TICKS_DEF   = 4;
   localparam int START_TIMEOUT_DEF = 64;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_vlg_rr_sel.sv
// Round-robin selector: first requester strictly after ptr_i, wrapping.
// Ports: req_i request vector, ptr_i last winner; gnt_o one-hot, idx_o index, any_o.
module mac_vlg_rr_sel
   import mac_vlg_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan from farthest to nearest so the nearest requester is written last.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = N; k >= 1; k--) begin
         int unsigned   c;
         logic [IW-1:0] ci;
         c  = (32'(ptr_i) + 32'(k)) % 32'(N);
         ci = IW'(c);
         if (req_i[ci]) begin
            gnt_o     = '0;
            gnt_o[ci] = 1'b1;
            idx_o     = ci;
            any_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_vlg_tx_arb.sv
// Round-robin transmit arbiter in front of the MAC TX request/stream path.
// Ports: per-source req/header/dat/val in, acc/done out (N-wide, flattened);
// MAC side req/header/dat/val out, busy in; timeout pulses on a revoked grant.
module mac_vlg_tx_arb
   import mac_vlg_pkg::*;
#(
   parameter int N             = 2,
   parameter int GUARD_TICKS   = GUARD_TICKS_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    src_req,
   input  logic [N*48-1:0] src_dst_mac,
   input  logic [N*16-1:0] src_ethertype,
   input  logic [N*16-1:0] src_length,
   output logic [N-1:0]    src_acc,
   input  logic [N*8-1:0]  src_dat,
   input  logic [N-1:0]    src_val,
   output logic [N-1:0]    src_done,
   output logic            mac_req,
   output logic [47:0]     mac_dst_mac,
   output logic [15:0]     mac_ethertype,
   output logic [15:0]     mac_length,
   input  logic            mac_busy,
   output logic [7:0]      mac_dat,
   output logic            mac_val,
   output logic            timeout
);

   localparam int IW = idx_w(N);
   localparam int TW = $clog2(START_TIMEOUT) + 1;
   localparam int GW = $clog2(GUARD_TICKS) + 1;

   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   mac_hdr_t      hdr_q, hdr_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [GW-1:0] gd_cnt_q, gd_cnt_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  done_q, done_d;
   logic          req_q, req_d;
   logic          val_q, val_d;
   logic          tmo_q, tmo_d;
   logic [7:0]    dat_q, dat_d;

   logic [N-1:0]  sel_gnt;
   logic [IW-1:0] sel_idx;
   logic          sel_any;
   mac_hdr_t      sel_hdr;
   logic [N-1:0]  win_oh;
   logic          w_val;
   logic [7:0]    w_dat;

   mac_vlg_rr_sel #(
      .N  (N),
      .IW (IW)
   ) u_sel (
      .req_i (src_req),
      .ptr_i (ptr_q),
      .gnt_o (sel_gnt),
      .idx_o (sel_idx),
      .any_o (sel_any)
   );

   // ptr_q doubles as the current winner while a grant is held.
   always_comb begin
      sel_hdr = '0;
      win_oh  = '0;
      w_val   = 1'b0;
      w_dat   = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_gnt[i]) begin
            sel_hdr.dst_mac   = src_dst_mac[i*48 +: 48];
            sel_hdr.ethertype = src_ethertype[i*16 +: 16];
            sel_hdr.length    = src_length[i*16 +: 16];
         end
         if (IW'(i) == ptr_q) begin
            win_oh[i] = 1'b1;
            w_val     = src_val[i];
            w_dat     = src_dat[i*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      hdr_d    = hdr_q;
      to_cnt_d = to_cnt_q;
      gd_cnt_d = gd_cnt_q;
      acc_d    = '0;
      done_d   = '0;
      req_d    = req_q;
      val_d    = 1'b0;
      tmo_d    = 1'b0;
      dat_d    = dat_q;
      unique case (state_q)
         IDLE: begin
            if (sel_any && !mac_busy) begin
               state_d  = GRANT;
               ptr_d    = sel_idx;
               hdr_d    = sel_hdr;
               acc_d    = sel_gnt;
               req_d    = 1'b1;
               to_cnt_d = '0;
            end
         end
         GRANT: begin
            if (w_val) begin
               state_d = PASS;
               val_d   = 1'b1;
               dat_d   = w_dat;
            end else if (int'(to_cnt_q) >= START_TIMEOUT - 1) begin
               state_d  = GUARD;
               tmo_d    = 1'b1;
               done_d   = win_oh;
               req_d    = 1'b0;
               gd_cnt_d = '0;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         PASS: begin
            val_d = w_val;
            dat_d = w_dat;
            // No gaps inside a frame: the first idle cycle ends it.
            if (!w_val) begin
               state_d  = GUARD;
               done_d   = win_oh;
               req_d    = 1'b0;
               gd_cnt_d = '0;
            end
         end
         GUARD: begin
            if (int'(gd_cnt_q) >= GUARD_TICKS - 1) begin
               state_d = IDLE;
            end else if (gd_cnt_q != '1) begin
               gd_cnt_d = gd_cnt_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         hdr_q    <= '0;
         to_cnt_q <= '0;
         gd_cnt_q <= '0;
         acc_q    <= '0;
         done_q   <= '0;
         req_q    <= 1'b0;
         val_q    <= 1'b0;
         tmo_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hdr_q    <= hdr_d;
         to_cnt_q <= to_cnt_d;
         gd_cnt_q <= gd_cnt_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         req_q    <= req_d;
         val_q    <= val_d;
         tmo_q    <= tmo_d;
         dat_q    <= dat_d;
      end
   end

   assign src_acc       = acc_q;
   assign src_done      = done_q;
   assign mac_req       = req_q;
   assign mac_dst_mac   = hdr_q.dst_mac;
   assign mac_ethertype = hdr_q.ethertype;
   assign mac_length    = hdr_q.length;
   assign mac_dat       = dat_q;
   assign mac_val       = val_q;
   assign timeout       = tmo_q;

endmodule

// File: tb/tb_mac_vlg_tx_arb.sv
// Directed and randomized bench for the MAC transmit arbiter.
// Grant order, byte stream, done/timeout timing come from a small reference model.
module tb_mac_vlg_tx_arb;

   localparam int N  = 2;
   localparam int G  = 4;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    src_req;
   logic [N*48-1:0] src_dst_mac;
   logic [N*16-1:0] src_ethertype;
   logic [N*16-1:0] src_length;
   logic [N-1:0]    src_acc;
   logic [N*8-1:0]  src_dat;
   logic [N-1:0]    src_val;
   logic [N-1:0]    src_done;
   logic            mac_req;
   logic [47:0]     mac_dst_mac;
   logic [15:0]     mac_ethertype;
   logic [15:0]     mac_length;
   logic            mac_busy;
   logic [7:0]      mac_dat;
   logic            mac_val;
   logic            timeout;

   always #5 clk = ~clk;

   mac_vlg_tx_arb #(
      .N             (N),
      .GUARD_TICKS   (G),
      .START_TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .src_req       (src_req),
      .src_dst_mac   (src_dst_mac),
      .src_ethertype (src_ethertype),
      .src_length    (src_length),
      .src_acc       (src_acc),
      .src_dat       (src_dat),
      .src_val       (src_val),
      .src_done      (src_done),
      .mac_req       (mac_req),
      .mac_dst_mac   (mac_dst_mac),
      .mac_ethertype (mac_ethertype),
      .mac_length    (mac_length),
      .mac_busy      (mac_busy),
      .mac_dat       (mac_dat),
      .mac_val       (mac_val),
      .timeout       (timeout)
   );

   int          errors = 0;
   int          checks = 0;
   int          ptr_m  = 0;
   int          aa_seen = 0;
   logic [47:0] h_dst [N];
   logic [15:0] h_et  [N];
   logic [15:0] h_len [N];
   logic [N-1:0] pend;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_hdrs();
      for (int s = 0; s < N; s++) begin
         src_dst_mac[s*48 +: 48]   = h_dst[s];
         src_ethertype[s*16 +: 16] = h_et[s];
         src_length[s*16 +: 16]    = h_len[s];
      end
   endtask

   // Winner = first requester after the last winner, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (p + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst      = 1'b1;
      src_req  = '0;
      src_val  = '0;
      src_dat  = '0;
      mac_busy = 1'b0;
      repeat (2) tick();
      rst   = 1'b0;
      ptr_m = 0;
   endtask

   task automatic wait_grant(input int s, input int exp_wait);
      int           n;
      logic [N-1:0] oh;
      n     = 0;
      oh    = '0;
      oh[s] = 1'b1;
      do begin
         tick();
         n++;
      end while (src_acc == '0 && n < 300);
      chk("grant_wait", 64'(n), 64'(exp_wait));
      chk("grant_acc", 64'(src_acc), 64'(oh));
      chk("grant_req", 64'(mac_req), 64'(1));
      chk("grant_dst", 64'(mac_dst_mac), 64'(h_dst[s]));
      chk("grant_et", 64'(mac_ethertype), 64'(h_et[s]));
      chk("grant_len", 64'(mac_length), 64'(h_len[s]));
      src_req[s] = 1'b0;
      ptr_m      = s;
   endtask

   // Output byte must equal the winner's byte one cycle earlier.
   task automatic stream(input int s, input int nb, input bit seq,
                         input bit iso);
      int           o;
      logic [7:0]   b;
      logic [N-1:0] oh;
      o     = (s + 1) % N;
      oh    = '0;
      oh[s] = 1'b1;
      for (int k = 0; k < nb; k++) begin
         b = seq ? 8'(k) : 8'($urandom_range(0, 255));
         src_val[s]         = 1'b1;
         src_dat[s*8 +: 8]  = b;
         src_val[o]         = iso ? ~src_val[o] : 1'($urandom_range(0, 1));
         src_dat[o*8 +: 8]  = iso ? 8'hAA : 8'($urandom_range(0, 255));
         tick();
         if (iso && mac_dat == 8'hAA) aa_seen++;
         chk("byte_val", 64'(mac_val), 64'(1));
         chk("byte_dat", 64'(mac_dat), 64'(b));
         chk("byte_req", 64'(mac_req), 64'(1));
         chk("byte_nodone", 64'(src_done), 64'(0));
      end
      src_val = '0;
      tick();
      chk("eof_val", 64'(mac_val), 64'(0));
      chk("eof_done", 64'(src_done), 64'(oh));
      chk("eof_req", 64'(mac_req), 64'(0));
      chk("eof_tmo", 64'(timeout), 64'(0));
   endtask

   task automatic gap();
      int bad;
      bad = 0;
      for (int k = 0; k <= G; k++) begin
         tick();
         if (mac_val || src_acc != '0 || src_done != '0) bad++;
      end
      chk("gap_quiet", 64'(bad), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst           = 1'b1;
      src_req       = '0;
      src_val       = '0;
      src_dat       = '0;
      mac_busy      = 1'b0;
      src_dst_mac   = '0;
      src_ethertype = '0;
      src_length    = '0;
      pend          = '0;

      // Reset state
      do_reset();
      chk("rst_acc", 64'(src_acc), 64'(0));
      chk("rst_done", 64'(src_done), 64'(0));
      chk("rst_req", 64'(mac_req), 64'(0));
      chk("rst_val", 64'(mac_val), 64'(0));
      chk("rst_tmo", 64'(timeout), 64'(0));
      chk("rst_dat", 64'(mac_dat), 64'(0));
      chk("rst_dst", 64'(mac_dst_mac), 64'(0));
      chk("rst_et", 64'(mac_ethertype), 64'(0));
      chk("rst_len", 64'(mac_length), 64'(0));

      // Single ARP frame from source 0
      h_dst[0] = 48'hFFFF_FFFF_FFFF;
      h_et[0]  = 16'h0806;
      h_len[0] = 16'd42;
      h_dst[1] = 48'h0200_0000_0001;
      h_et[1]  = 16'h0800;
      h_len[1] = 16'd60;
      set_hdrs();
      src_req[0] = 1'b1;
      wait_grant(0, 1);
      stream(0, 42, 1'b1, 1'b0);
      gap();

      // Contention from reset: order 1,0,1,0
      do_reset();
      src_req = 2'b11;
      wait_grant(1, 1);
      src_req[1] = 1'b1;
      stream(1, 8, 1'b0, 1'b0);
      wait_grant(0, G + 1);
      src_req[0] = 1'b1;
      stream(0, 8, 1'b0, 1'b0);
      wait_grant(1, G + 1);
      stream(1, 8, 1'b0, 1'b0);
      wait_grant(0, G + 1);
      stream(0, 8, 1'b0, 1'b0);
      gap();

      // Start timeout on source 0, then source 1 after guard
      src_req[0] = 1'b1;
      wait_grant(0, 1);
      src_req[1] = 1'b1;
      cnt = 0;
      repeat (TO - 1) begin
         tick();
         if (timeout || src_done != '0 || !mac_req) cnt++;
      end
      chk("to_early", 64'(cnt), 64'(0));
      tick();
      chk("to_pulse", 64'(timeout), 64'(1));
      chk("to_done", 64'(src_done), 64'(2'b01));
      chk("to_req", 64'(mac_req), 64'(0));
      chk("to_val", 64'(mac_val), 64'(0));
      tick();
      chk("to_once", 64'(timeout), 64'(0));
      wait_grant(1, G);
      stream(1, 5, 1'b0, 1'b0);
      gap();

      // Busy hold-off; busy during a frame is ignored
      mac_busy   = 1'b1;
      src_req[1] = 1'b1;
      cnt = 0;
      repeat (20) begin
         tick();
         if (src_acc != '0) cnt++;
      end
      chk("busy_hold", 64'(cnt), 64'(0));
      mac_busy = 1'b0;
      wait_grant(1, 1);
      mac_busy = 1'b1;
      stream(1, 6, 1'b0, 1'b0);
      mac_busy = 1'b0;
      gap();

      // Isolation from the non-granted source
      src_req[0] = 1'b1;
      wait_grant(0, 1);
      stream(0, 20, 1'b1, 1'b1);
      chk("iso_aa", 64'(aa_seen), 64'(0));
      gap();

      // Reset at byte 10 of a 60-byte frame from source 1
      src_req[1] = 1'b1;
      wait_grant(1, 1);
      for (int k = 0; k < 10; k++) begin
         src_val[1]     = 1'b1;
         src_dat[15:8]  = 8'(k + 8'h30);
         tick();
         chk("mid_dat", 64'(mac_dat), 64'(k + 8'h30));
      end
      src_dat[15:8] = 8'h3A;
      rst           = 1'b1;
      tick();
      chk("mrst_val", 64'(mac_val), 64'(0));
      chk("mrst_req", 64'(mac_req), 64'(0));
      chk("mrst_acc", 64'(src_acc), 64'(0));
      chk("mrst_done", 64'(src_done), 64'(0));
      rst     = 1'b0;
      src_val = '0;
      ptr_m   = 0;
      cnt     = 0;
      repeat (3) begin
         tick();
         if (src_done != '0 || mac_val || mac_req) cnt++;
      end
      chk("mrst_quiet", 64'(cnt), 64'(0));
      src_req = 2'b11;
      wait_grant(1, 1);
      stream(1, 4, 1'b0, 1'b0);
      wait_grant(0, G + 1);
      stream(0, 4, 1'b0, 1'b0);
      gap();

      // Randomized traffic against the round-robin model
      for (int s = 0; s < N; s++) begin
         h_dst[s] = 48'({$urandom, $urandom});
         h_et[s]  = 16'($urandom);
         h_len[s] = 16'($urandom);
      end
      set_hdrs();
      pend = '0;
      for (int it = 0; it < 16; it++) begin
         logic [N-1:0] nw;
         int           w;
         int           ew;
         int           bz;
         nw = N'($urandom_range(0, (1 << N) - 1));
         if (pend == '0) begin
            if (nw == '0) nw[$urandom_range(0, N - 1)] = 1'b1;
            pend     = nw;
            bz       = $urandom_range(0, 4);
            mac_busy = (bz != 0);
            src_req  = pend;
            repeat (bz) tick();
            mac_busy = 1'b0;
            ew       = 1;
         end else begin
            pend    = pend | nw;
            src_req = pend;
            ew      = G + 1;
         end
         w = rr_pick(pend, ptr_m);
         wait_grant(w, ew);
         pend[w] = 1'b0;
         stream(w, $urandom_range(1, 16), 1'b0, 1'b0);
         if (pend == '0) gap();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_vlg_tx_arb.md
Name: mac_vlg_tx_arb

Overview:
- Multi-source transmit arbiter that sits directly upstream of the MAC transmit path.
- Collects frame requests from N protocol engines (ARP, IPv4/ICMP/TCP/UDP, ...) and selects one round-robin.
- Latches the winner's Ethernet header fields, then forwards its byte stream to the MAC TX request/stream interface.
- Holds the grant for a whole frame, releases after end-of-frame plus a guard gap, and includes a start-timeout so a stalled source cannot lock the transmitter.

Parameters:
- N, 2, number of requesting sources (1..8).
- GUARD_TICKS, 4, idle cycles after a frame before the next grant.
- START_TIMEOUT, 64, max cycles from grant to first valid byte before the grant is revoked.

Ports:
- clk  in  1  system clock, MAC local domain.
- rst  in  1  synchronous, active-high reset.
- src_req  in  N  source i has a frame pending; level, held until granted.
- src_dst_mac  in  N*48  destination MAC per source.
- src_ethertype  in  N*16  ethertype per source.
- src_length  in  N*16  payload length per source.
- src_acc  out  N  one-cycle grant pulse to source i.
- src_dat  in  N*8  payload byte per source.
- src_val  in  N  payload valid per source.
- src_done  out  N  one-cycle pulse when source i's frame has completed or been revoked.
- mac_req  out  1  frame request to MAC TX.
- mac_dst_mac  out  48  latched destination MAC.
- mac_ethertype  out  16  latched ethertype.
- mac_length  out  16  latched length.
- mac_busy  in  1  MAC TX is currently sending.
- mac_dat  out  8  forwarded byte.
- mac_val  out  1  forwarded valid.
- timeout  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset: state IDLE. src_acc, src_done, mac_req, mac_val and timeout are 0. mac_dat, mac_dst_mac, mac_ethertype and mac_length are 0. Round-robin pointer is 0. Counters are 0.
- IDLE:
  - Move to GRANT when any src_req is high and mac_busy is low.
  - Winner is the first requester at index ≥ (ptr+1) mod N, wrapping.
  - Latch the winner index and its header fields.
  - Pulse src_acc[winner] for one cycle on the transition edge.
  - Set ptr to winner.
- GRANT:
  - Drive mac_req high with the latched header; the cycle counter starts at 0.
  - If src_val[winner] goes high, enter PASS. That byte is forwarded on the same cycle the state changes, so mac_val/mac_dat have 1 register stage of latency from src_*.
  - If the counter reaches START_TIMEOUT-1 with no valid byte: pulse timeout and src_done[winner], drop mac_req, go to GUARD.
- PASS:
  - mac_dat/mac_val are src_dat/src_val of the winner, registered once.
  - Inputs from non-granted sources are ignored entirely.
  - mac_req is held high until the first cycle src_val[winner] is low.
  - That cycle is end-of-frame: the registered output emits val=0 next cycle, src_done[winner] pulses, mac_req drops, go to GUARD.
  - Gaps inside a frame are not supported; a val drop is end-of-frame.
- GUARD:
  - Hold mac_val=0 for GUARD_TICKS cycles, then return to IDLE.
  - No grant is issued in GUARD even if requests are pending.
- Simultaneous requests are resolved by round-robin only; a source re-requesting immediately cannot win twice while another is pending.
- Single requester: the same source may win consecutively, separated by the guard gap.
- src_req of the winner dropping mid-frame is ignored; only src_val matters after the grant.
- Reset mid-frame returns to IDLE within one cycle. mac_val and mac_req go to 0 with no done pulse, and ptr returns to 0.
- mac_busy asserted in GRANT/PASS has no effect; it is checked only in IDLE.
- Counters are sized by $clog2 of their parameter plus 1 and saturate; there is no wrap.

Decomposition:
- Package (mac_vlg_pkg) contents:
  - typedef of the arbiter state enum (IDLE, GRANT, PASS, GUARD).
  - struct mac_hdr_t {dst_mac, ethertype, length}.
  - Constants for default GUARD_TICKS and START_TIMEOUT.
- One natural sub-module, mac_vlg_rr_sel: a combinational-plus-pointer round-robin selector taking a req vector and a pointer and returning a one-hot grant and its index. It is reusable by the IP-layer multiplexers.

Test Plan:
- Single frame: src_req[0]=1, header dst=FF:FF:FF:FF:FF:FF, ethertype 0x0806, 42 bytes 0x00..0x29.
  - Expect one src_acc[0] pulse, mac_req high with the same header, and 42 mac_val bytes 1 cycle delayed in order.
  - Expect src_done[0] 1 cycle after the last byte, then 4 idle cycles.
- Contention: src_req[0] and src_req[1] asserted together from reset.
  - Expect source 1 granted first (ptr=0), then source 0 after guard; re-asserting 1 immediately yields the order 1,0,1,0.
- Timeout: grant source 0, never assert src_val.
  - Expect timeout and src_done[0] pulses at cycle 64 after grant, mac_req low, and source 1 granted after guard.
- Busy hold-off: mac_busy=1 with src_req[1]=1 for 20 cycles.
  - Expect no src_acc; grant occurs 1 cycle after mac_busy falls.
- Isolation: during a source 0 frame, toggle src_val[1]/src_dat[1]=0xAA.
  - Expect 0xAA never appears on mac_dat.
- Reset mid-frame: assert rst at byte 10 of a 60-byte frame.
  - Expect mac_val=0, mac_req=0 and all src_acc/src_done=0 the following cycle, with no done pulse.
